// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU-sharing controller.
// Holds the ALU function codes, the controller state encoding and the
// owner encoding.
//   Owner codes are one-hot per requester, so an arbiter grant can be
//   copied straight into the owner register.
package alu_ctrl_pkg;

    // ALU function codes
    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_SUB  = 3'b001;
    localparam logic [2:0] FN_AND  = 3'b010;
    localparam logic [2:0] FN_OR   = 3'b011;
    localparam logic [2:0] FN_XOR  = 3'b100;
    localparam logic [2:0] FN_SHL  = 3'b101;
    localparam logic [2:0] FN_MUL  = 3'b110;
    localparam logic [2:0] FN_HOLD = 3'b111;

    // Owner encoding (one-hot per requester, 00 = nobody)
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_REQ0 = 2'b01;
    localparam logic [1:0] OWN_REQ1 = 2'b10;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_EXEC  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   Clock   in   1  clock, posedge
//   Reset   in   1  synchronous, active-high; pointer favours req[0]
//   req     in   2  request vector
//   update  in   1  commit the current grant; pointer then favours the other side
//   grant   out  2  one-hot grant (combinational from req and pointer)
module rr_arb2 (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic prefer_req1_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            prefer_req1_q <= 1'b0;
        end else if (update) begin
            // Serving req0 hands priority to req1, serving req1 hands it back.
            prefer_req1_q <= grant[0];
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prefer_req1_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered accumulator ALU between two requesters.
// A requester owns the ALU for a whole burst (until an op flagged last, or
// until it stalls TIMEOUT cycles); the ALU is cleared at the start of every
// burst and ops are executed one at a time, each result returned as a pulse.
//   Clock, Reset            clock and synchronous active-high reset
//   reqN_valid/data/func/last, reqN_ready   op handshake per requester (N=0,1)
//   respN_valid/result      one-cycle result pulse per requester
//   respN_abort             one-cycle pulse when a stalled burst is dropped
//   alu_reset_b, alu_data, alu_function     drive the shared ALU
//   alu_out                 ALU registered accumulator output
//   owner                   00 none, 01 req0, 10 req1
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_data,
    input  logic [2:0] req0_func,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_data,
    input  logic [2:0] req1_func,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       resp0_valid,
    output logic [7:0] resp0_result,
    output logic       resp0_abort,
    output logic       resp1_valid,
    output logic [7:0] resp1_result,
    output logic       resp1_abort,
    output logic       alu_reset_b,
    output logic [3:0] alu_data,
    output logic [2:0] alu_function,
    input  logic [7:0] alu_out,
    output logic [1:0] owner
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

    state_e           state_q, state_n;
    logic [1:0]       owner_q, owner_n;
    logic             last_q, last_n;
    logic [TMO_W-1:0] tmo_q, tmo_n;

    logic [1:0]       grant;
    logic             arb_update;

    logic             own_valid;
    logic             own_last;
    logic [3:0]       own_data;
    logic [2:0]       own_func;
    logic             hs;

    logic [1:0]       ready_q, ready_n;
    logic [1:0]       resp_q, resp_n;
    logic [1:0]       abort_q, abort_n;
    logic             alu_reset_b_q, alu_reset_b_n;
    logic [3:0]       alu_data_q, alu_data_n;
    logic [2:0]       alu_func_q, alu_func_n;

    rr_arb2 u_arb (
        .Clock  (Clock),
        .Reset  (Reset),
        .req    ({req1_valid, req0_valid}),
        .update (arb_update),
        .grant  (grant)
    );

    // Select the current owner's request signals.
    always_comb begin
        own_valid = req0_valid;
        own_last  = req0_last;
        own_data  = req0_data;
        own_func  = req0_func;
        if (owner_q[1]) begin
            own_valid = req1_valid;
            own_last  = req1_last;
            own_data  = req1_data;
            own_func  = req1_func;
        end
    end

    assign hs = (state_q == ST_ISSUE) && own_valid && ((ready_q & owner_q) != 2'b00);

    // Next state and next values of all registered outputs. Outputs are
    // derived from the next state so they line up with the state they
    // belong to in the same cycle.
    always_comb begin
        state_n    = state_q;
        owner_n    = owner_q;
        last_n     = last_q;
        tmo_n      = '0;
        arb_update = 1'b0;
        abort_n    = 2'b00;
        alu_data_n = alu_data_q;
        alu_func_n = FN_HOLD;

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    owner_n    = grant;
                    arb_update = 1'b1;
                    state_n    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_n = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (hs) begin
                    // The ALU input registers double as the op capture registers.
                    last_n     = own_last;
                    alu_data_n = own_data;
                    alu_func_n = own_func;
                    state_n    = ST_EXEC;
                end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                    abort_n = owner_q;
                    owner_n = OWN_NONE;
                    state_n = ST_IDLE;
                end else begin
                    tmo_n = tmo_q + 1'b1;
                end
            end
            ST_EXEC: begin
                state_n = ST_RESP;
            end
            ST_RESP: begin
                if (last_q) begin
                    owner_n = OWN_NONE;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_ISSUE;
                end
            end
            default: begin
                owner_n = OWN_NONE;
                state_n = ST_IDLE;
            end
        endcase

        ready_n       = (state_n == ST_ISSUE) ? owner_n : 2'b00;
        resp_n        = (state_n == ST_RESP)  ? owner_n : 2'b00;
        alu_reset_b_n = (state_n != ST_CLEAR);
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_NONE;
            tmo_q         <= '0;
            ready_q       <= 2'b00;
            resp_q        <= 2'b00;
            abort_q       <= 2'b00;
            alu_reset_b_q <= 1'b0;
            alu_data_q    <= 4'h0;
            alu_func_q    <= FN_HOLD;
        end else begin
            state_q       <= state_n;
            owner_q       <= owner_n;
            tmo_q         <= tmo_n;
            ready_q       <= ready_n;
            resp_q        <= resp_n;
            abort_q       <= abort_n;
            alu_reset_b_q <= alu_reset_b_n;
            alu_data_q    <= alu_data_n;
            alu_func_q    <= alu_func_n;
        end
    end

    // Last-op flag is only read in RESP, which always follows a capture.
    always_ff @(posedge Clock) begin
        last_q <= last_n;
    end

    assign req0_ready   = ready_q[0];
    assign req1_ready   = ready_q[1];
    assign resp0_valid  = resp_q[0];
    assign resp1_valid  = resp_q[1];
    assign resp0_abort  = abort_q[0];
    assign resp1_abort  = abort_q[1];
    assign alu_reset_b  = alu_reset_b_q;
    assign alu_data     = alu_data_q;
    assign alu_function = alu_func_q;
    assign owner        = owner_q;

    // alu_out is itself a register output of the ALU and is only valid in
    // the RESP cycle, so it is gated by the registered pulse rather than
    // re-registered (which would add a cycle of latency).
    assign resp0_result = resp_q[0] ? alu_out : 8'h00;
    assign resp1_result = resp_q[1] ? alu_out : 8'h00;

endmodule
